five_bit_serial_subtractor: RTL and testbench
=============================================

Name: five_bit_serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor. It computes DIFF = A - B (mod 2^WIDTH) one bit per clock, LSB first, using a registered borrow.
- It is the inverse-direction counterpart of the combinational five-bit ripple adder in the snake datapath.
- It is used for position deltas and for length/score decrements.
- Operands are accepted and results returned over valid/ready handshakes, so the block sits between the game-state FSM and the position/score registers.

Parameters:
- WIDTH, 5, operand/result bit width (must be >= 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair A/B valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- DIFF  output  WIDTH  A - B modulo 2^WIDTH.
- BORROW  output  1  1 when A < B (unsigned).
- ZERO  output  1  1 when DIFF == 0.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates occur on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, DIFF=0, BORROW=0, ZERO=0. Internal A/B shift registers, bit counter and borrow are cleared.
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready: latch A and B into shift registers, clear the borrow and result registers, counter=0, go to SHIFT.
  - SHIFT: in_ready=0.
    - Each cycle: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
    - Shift d into the MSB of the result register (right shift). Shift the A/B registers right; counter += 1.
    - When the counter reaches WIDTH-1 on this edge, go to DONE.
  - DONE: out_valid=1, in_ready=0.
    - DIFF holds the full result. BORROW = final borrow. ZERO = (DIFF == 0).
    - On out_ready: out_valid clears on that edge and the FSM returns to IDLE.
- Latency: with operands accepted on edge E0, bits are produced on edges E1..E_WIDTH, and out_valid is high in the cycle after E_WIDTH. For the default, out_valid rises WIDTH+1 = 6 cycles after acceptance.
- Throughput: one operation per WIDTH+2 cycles minimum. There is no accept in the same cycle as a result handoff; in_ready only rises in IDLE.
- DIFF, BORROW and ZERO are valid only while out_valid=1. They hold stable until handoff, and are held at their last values afterwards (not cleared).
- in_valid while in SHIFT or DONE is ignored (in_ready=0). A and B are sampled only at acceptance; later changes have no effect on the result.
- out_ready while out_valid=0 is ignored.
- Backpressure: DONE is held indefinitely with outputs stable while out_ready=0.
- Wrap-around: results are modulo 2^WIDTH. For example, 0 - 1 gives DIFF=all ones with BORROW=1.
- Reset mid-operation (SHIFT or DONE): abort, return to reset values next edge; no result is emitted.
- rst has priority over all handshakes in the same cycle.

Test Plan:
- Reset then A=13, B=6, in_valid pulse -> out_valid rises 6 cycles after accept; DIFF=7, BORROW=0, ZERO=0.
- A=6, B=13 -> DIFF=25, BORROW=1, ZERO=0. A=0, B=31 -> DIFF=1, BORROW=1.
- A=9, B=9 -> DIFF=0, ZERO=1, BORROW=0. A=0, B=0 -> DIFF=0, ZERO=1.
- Hold out_ready=0 for 10 cycles after out_valid -> DIFF/BORROW/ZERO/out_valid stable, in_ready=0. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 next cycle.
- While in SHIFT, drive in_valid=1 with A=31, B=0 -> ignored; the original result is returned. In the same run, change A/B after acceptance -> result unaffected.
- Assert rst in the 3rd SHIFT cycle -> next cycle in_ready=1, out_valid=0, outputs 0. A new op A=20, B=5 -> DIFF=15.

Source files
------------

// File: rtl/five_bit_serial_subtractor.sv
// five_bit_serial_subtractor: bit-serial A - B (mod 2^WIDTH), LSB first, with a registered borrow and valid/ready handshakes.
module five_bit_serial_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW,
  output logic             ZERO
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_nx;
  logic [CW-1:0] cnt;
  logic br, br_nx, d, last;
  always_comb begin
    d        = a_sr[0] ^ b_sr[0] ^ br;
    br_nx    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_nx   = {d, DIFF[WIDTH-1:1]};
    last     = cnt == CW'(WIDTH - 1);
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_nx = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
               state == SHIFT ? (last ? DONE : SHIFT) :
               state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // result bits enter at the MSB so after WIDTH shifts the LSB lands at bit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      DIFF   <= '0;
      BORROW <= 1'b0;
      ZERO   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sr   <= A;
      b_sr   <= B;
      cnt    <= '0;
      br     <= 1'b0;
      DIFF   <= '0;
      BORROW <= 1'b0;
      ZERO   <= 1'b0;
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      cnt  <= cnt + CW'(1);
      br   <= br_nx;
      DIFF <= res_nx;
      if (last) begin
        BORROW <= br_nx;
        ZERO   <= res_nx == '0;
      end
    end
  end
endmodule

// File: tb/tb_five_bit_serial_subtractor.sv
// tb_five_bit_serial_subtractor: table-driven vectors with a result scoreboard for the serial subtractor.
module tb_five_bit_serial_subtractor;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [4:0] A = 0, B = 0;
  logic in_ready, out_valid, BORROW, ZERO;
  logic [4:0] DIFF;
  int checks = 0, errors = 0;
  typedef struct {
    logic [4:0] a, b, diff;
    logic borrow, zero;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  always #5 clk = ~clk;
  five_bit_serial_subtractor #(.WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .DIFF(DIFF), .BORROW(BORROW), .ZERO(ZERO)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic vec_t model(input logic [4:0] a, input logic [4:0] b);
    vec_t v;
    logic [5:0] r;
    r = {1'b0, a} - {1'b0, b};
    v.a = a; v.b = b; v.diff = r[4:0]; v.borrow = r[5]; v.zero = r[4:0] == 0;
    return v;
  endfunction
  task automatic op(input vec_t v, input bit inject, input int hold);
    int lat;
    vec_t e;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; A = v.a; B = v.b;
    @(posedge clk);
    sb.push_back(v);
    @(negedge clk);
    in_valid = 0; A = 5'($urandom); B = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (inject && lat == 2) begin in_valid = 1; A = 31; B = 0; end
      @(negedge clk);
      lat++;
    end
    in_valid = 0;
    chk("latency", lat, 6);
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_diff", DIFF, e.diff);
      chk("hold_borrow", BORROW, e.borrow);
      chk("hold_zero", ZERO, e.zero);
      @(negedge clk);
    end
    chk($sformatf("diff_%0d_%0d", e.a, e.b), DIFF, e.diff);
    chk($sformatf("borrow_%0d_%0d", e.a, e.b), BORROW, e.borrow);
    chk($sformatf("zero_%0d_%0d", e.a, e.b), ZERO, e.zero);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("handoff_out_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
    chk("diff_held", DIFF, e.diff);
  endtask
  initial begin
    vecs.push_back('{5'd13, 5'd6, 5'd7, 1'b0, 1'b0});
    vecs.push_back('{5'd6, 5'd13, 5'd25, 1'b1, 1'b0});
    vecs.push_back('{5'd0, 5'd31, 5'd1, 1'b1, 1'b0});
    vecs.push_back('{5'd9, 5'd9, 5'd0, 1'b0, 1'b1});
    vecs.push_back('{5'd0, 5'd0, 5'd0, 1'b0, 1'b1});
    vecs.push_back('{5'd31, 5'd0, 5'd31, 1'b0, 1'b0});
    vecs.push_back('{5'd0, 5'd1, 5'd31, 1'b1, 1'b0});
    vecs.push_back('{5'd16, 5'd15, 5'd1, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) vecs.push_back(model(5'($urandom), 5'($urandom)));
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", DIFF, 0);
    chk("rst_borrow", BORROW, 0);
    chk("rst_zero", ZERO, 0);
    for (int i = 0; i < vecs.size(); i++) op(vecs[i], i == 0, i == 1 ? 10 : 0);
    in_valid = 1; A = 13; B = 6;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk("mid_in_ready", in_ready, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_diff", DIFF, 0);
    chk("abort_borrow", BORROW, 0);
    chk("abort_zero", ZERO, 0);
    op('{5'd20, 5'd5, 5'd15, 1'b0, 1'b0}, 0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
